// File: rtl/pwm_meter.sv
// Measures period, high time and duty cycle (percent) of an asynchronous periodic input.
// A 7-cycle restoring divider yields the duty; rises that arrive while it is busy are dropped.
module pwm_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic             valid_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic [6:0]       duty_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic             overrun_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MEAS = 1'b1;
  localparam int NUM_W = CNT_W + 7;
  // Last count value from which a rise is still accepted (2^CNT_W-2).
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lvl_d_q, lvl_d_d;
  logic [CNT_W-1:0]       run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]       hi_cnt_q, hi_cnt_d;
  logic [0:0]             state_q, state_d;
  logic                   busy_q, busy_d;
  logic [2:0]             iter_q, iter_d;
  logic [NUM_W-1:0]       rem_q, rem_d;
  logic [NUM_W-1:0]       dvs_q, dvs_d;
  logic [5:0]             quo_q, quo_d;
  logic [CNT_W-1:0]       p_q, p_d;
  logic [CNT_W-1:0]       h_q, h_d;
  logic                   valid_q, valid_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic [6:0]             duty_q, duty_d;
  logic                   timeout_q, timeout_d;

  logic lvl, rise, accept, abort, ovr, qbit;

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~lvl_d_q;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
    lvl_d_d   = lvl;
    run_cnt_d = rise ? {{(CNT_W-1){1'b0}}, 1'b1} : run_cnt_q + 1'b1;
    hi_cnt_d  = rise ? {{(CNT_W-1){1'b0}}, 1'b1} : (lvl ? hi_cnt_q + 1'b1 : hi_cnt_q);
    state_d   = state_q;
    accept    = 1'b0;
    abort     = 1'b0;
    ovr       = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: if (rise) state_d = S_MEAS;
      default: begin
        if (rise) begin
          if (busy_q) ovr = 1'b1;
          else        accept = 1'b1;
        end else if (run_cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          abort     = 1'b1;
          state_d   = S_IDLE;
        end
      end
    endcase

    busy_d   = busy_q;
    iter_d   = iter_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    p_d      = p_q;
    h_d      = h_q;
    valid_d  = 1'b0;
    period_d = period_q;
    high_d   = high_q;
    duty_d   = duty_q;
    qbit     = 1'b0;

    if (abort) begin
      busy_d = 1'b0;
    end else if (accept) begin
      busy_d = 1'b1;
      iter_d = 3'd6;
      rem_d  = NUM_W'(hi_cnt_q) * NUM_W'(100);
      // Divisor starts aligned to the MSB quotient bit (P << 6).
      dvs_d  = {1'b0, run_cnt_q, 6'b0};
      quo_d  = 6'b0;
      p_d    = run_cnt_q;
      h_d    = hi_cnt_q;
    end else if (busy_q) begin
      if (rem_q >= dvs_q) begin
        rem_d = rem_q - dvs_q;
        qbit  = 1'b1;
      end
      quo_d  = {quo_q[4:0], qbit};
      dvs_d  = dvs_q >> 1;
      iter_d = iter_q - 3'd1;
      if (iter_q == 3'd0) begin
        busy_d   = 1'b0;
        valid_d  = 1'b1;
        period_d = p_q;
        high_d   = h_q;
        duty_d   = {quo_q, qbit};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      lvl_d_q   <= 1'b0;
      run_cnt_q <= '0;
      hi_cnt_q  <= '0;
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      iter_q    <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      p_q       <= '0;
      h_q       <= '0;
      valid_q   <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      duty_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      lvl_d_q   <= lvl_d_d;
      run_cnt_q <= run_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      state_q   <= state_d;
      busy_q    <= busy_d;
      iter_q    <= iter_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      p_q       <= p_d;
      h_q       <= h_d;
      valid_q   <= valid_d;
      period_q  <= period_d;
      high_q    <= high_d;
      duty_q    <= duty_d;
      timeout_q <= timeout_d;
    end
  end

  assign valid_o   = valid_q;
  assign period_o  = period_q;
  assign high_o    = high_q;
  assign duty_o    = duty_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;
  assign overrun_o = ovr;

endmodule

// File: tb/tb_pwm_meter.sv
// Scoreboard bench for pwm_meter: stimulus pushes expected results, a monitor pops them on valid_o.
module tb_pwm_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_in = 1'b0;
  logic        valid_o;
  logic [15:0] period_o;
  logic [15:0] high_o;
  logic [6:0]  duty_o;
  logic        busy_o;
  logic        timeout_o;
  logic        overrun_o;

  pwm_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .valid_o   (valid_o),
    .period_o  (period_o),
    .high_o    (high_o),
    .duty_o    (duty_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o),
    .overrun_o (overrun_o)
  );

  always #10 clk = ~clk;

  typedef struct {
    int period;
    int high;
    int duty;
    int gap;    // expected cycles since previous valid_o, 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   ov_cnt = 0;
  int   to_cnt = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int p, input int h, input int d, input int g);
    exp_t e;
    e.period = p; e.high = h; e.duty = d; e.gap = g;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every reported result against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (overrun_o) ov_cnt++;
      if (timeout_o) to_cnt++;
      if (valid_o) begin
        check("valid_without_timeout", int'(timeout_o), 0);
        check("result_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("period_o", int'(period_o), e.period);
          check("high_o", int'(high_o), e.high);
          check("duty_o", int'(duty_o), e.duty);
          if (e.gap != 0) check("valid_spacing", cyc - last_valid_cyc, e.gap);
        end
        last_valid_cyc = cyc;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic train(input int period, input int high, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      wait_cyc(high);
      sig_in = 1'b0;
      wait_cyc(period - high);
    end
  endtask

  task automatic do_reset();
    sig_in = 1'b0;
    rst_n  = 1'b0;
    wait_cyc(3);
    rst_n  = 1'b1;
    wait_cyc(2);
    ov_cnt = 0;
    to_cnt = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, int'(valid_o), 0);
    check({tag, "_period"}, int'(period_o), 0);
    check({tag, "_high"}, int'(high_o), 0);
    check({tag, "_duty"}, int'(duty_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_timeout"}, int'(timeout_o), 0);
    check({tag, "_overrun"}, int'(overrun_o), 0);
  endtask

  task automatic end_phase(input string tag, input int exp_ov);
    wait_cyc(40);
    check({tag, "_scoreboard_drained"}, exp_q.size(), 0);
    check({tag, "_overruns"}, ov_cnt, exp_ov);
  endtask

  initial begin
    int n;
    #5;
    check_idle_outputs("reset");
    wait_cyc(2);
    do_reset();

    // 400 ns period, 160 ns high: first rise only arms
    push(20, 8, 40, 0);
    for (int i = 0; i < 3; i++) push(20, 8, 40, 20);
    train(20, 8, 5);
    end_phase("p20h8", 0);

    // Truncation and near-full duty
    do_reset();
    push(100, 33, 33, 0);
    push(100, 33, 33, 100);
    train(100, 33, 3);
    end_phase("p100h33", 0);
    do_reset();
    push(100, 99, 99, 0);
    push(100, 99, 99, 100);
    train(100, 99, 3);
    end_phase("p100h99", 0);

    // Period shorter than the divider: alternate rises overrun
    do_reset();
    push(5, 2, 40, 0);
    push(5, 2, 40, 10);
    train(5, 2, 5);
    end_phase("p5h2", 2);

    // Held high after an arming rise: timeout 65535 cycles after the rise
    do_reset();
    sig_in = 1'b1;
    n = 0;
    while (n < 70000) begin
      @(negedge clk);
      n++;
      if (timeout_o) break;
    end
    check("timeout_latency", n, 65538);
    wait_cyc(5);
    check("timeout_pulses", to_cnt, 1);
    sig_in = 1'b0;
    wait_cyc(5);
    push(20, 8, 40, 0);
    train(20, 8, 2);
    end_phase("after_timeout", 0);
    check("timeout_pulses_final", to_cnt, 1);

    // Reset in the middle of a division
    do_reset();
    train(20, 8, 1);
    sig_in = 1'b1;
    wait_cyc(5);
    check("busy_before_reset", int'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    wait_cyc(3);
    sig_in = 1'b0;
    rst_n = 1'b1;
    wait_cyc(20);
    check("no_result_after_reset", exp_q.size(), 0);
    push(20, 8, 40, 0);
    push(20, 8, 40, 20);
    train(20, 8, 3);
    end_phase("after_reset", 0);

    // Period change 20 -> 50 with a different high time
    do_reset();
    push(20, 8, 40, 0);
    push(20, 8, 40, 20);
    push(20, 8, 40, 20);
    push(50, 15, 30, 50);
    train(20, 8, 3);
    train(50, 15, 2);
    end_phase("period_change", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_meter.md
# pwm_meter

Synthesizable measurement block that characterises an incoming periodic digital signal. It reports period, high time (both in system-clock cycles) and integer duty cycle in percent. It is the receive-side counterpart of the testbench waveform generators that drive a signal from a requested period and duty cycle, and it lets benches and on-chip monitors check such signals cycle-accurately. It sits between any asynchronous square-wave source and a register/monitor consumer.

## Interface
- CNT_W, 16, width of period/high counters; max measurable period 2^CNT_W-2 cycles
- SYNC_STAGES, 2, synchronizer flops on sig_in (≥2)
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- sig_in  input  1  measured signal, asynchronous to clk
- valid_o  output  1  one-cycle pulse: period_o/high_o/duty_o updated this cycle
- period_o  output  CNT_W  cycles between consecutive rising edges
- high_o  output  CNT_W  cycles signal was high within that period
- duty_o  output  7  floor(high_o*100/period_o), range 0..99
- busy_o  output  1  divider in progress
- timeout_o  output  1  one-cycle pulse: no rising edge within 2^CNT_W-1 cycles
- overrun_o  output  1  one-cycle pulse: a period result was dropped because the divider was busy

## Operation
- sig_in passes through SYNC_STAGES flops to give lvl. A delay flop gives lvl_d. rise = lvl & ~lvl_d; fall = ~lvl & lvl_d.
- Counters:
  - run_cnt: on rise, load 1; otherwise increment by 1.
  - hi_cnt: on rise, load 1; else if lvl=1, increment; else hold.
- FSM states:
  - IDLE: counters free; first rise arms and goes to MEAS. No result.
  - MEAS: on rise, if divider idle, latch P=run_cnt and H=hi_cnt, start divider, reload counters. If divider busy, reload counters, drop result, pulse overrun_o.
  - On the cycle run_cnt would reach 2^CNT_W-1: pulse timeout_o, go to IDLE, abort the divider without producing a result.
- Divider: restoring long division, one quotient bit per cycle, MSB first, 7 iterations. Numerator N = H*100 (CNT_W+7 bits), divisor P. Since H<P, N<128·P, so 7 quotient bits suffice. Remainder is discarded.
- Divider runs independently of MEAS. Counting continues during division.
- Edge cases:
  - H=0 is impossible: high_o ≥ 1 whenever valid_o.
  - Minimum measurable period is 2 cycles (post-synchronizer).
  - Glitches shorter than one clk are filtered or stretched by the synchronizer; no further debounce.

## Timing
- Reset (async assert, sync release): all outputs 0, FSM=IDLE, counters 0, synchronizer flops 0.
- Input to rise latency: SYNC_STAGES+1 clk edges.
- Rise detected in cycle t (divider idle): busy_o=1 in cycles t+1..t+7. valid_o=1 in cycle t+8, with period_o/high_o/duty_o updated in that same cycle. The outputs then hold until the next valid_o.
- Minimum result spacing is 8 cycles. A rise in cycles t+1..t+7 causes overrun_o in the rise cycle and leaves the in-flight result intact.
- timeout_o and valid_o are never asserted in the same cycle. A timeout during busy cancels the pending valid_o.
- rst_n asserted mid-division or mid-period: immediate return to the reset state. The first rise after release only arms the FSM.

## Test plan
- CNT_W=16, clk 20 ns; sig_in 400 ns period, 40 % duty (160 ns high), 5 periods:
  - no valid_o on the first rise
  - then valid_o every 20 cycles with period_o=20, high_o=8, duty_o=40
  - overrun_o=0
- Period 100 cycles, high 33 cycles → period_o=100, high_o=33, duty_o=33 (truncation check). High 99 of 100 → duty_o=99.
- Period 5 cycles, high 2 → every other period reports period_o=5, high_o=2, duty_o=40; the alternate rises pulse overrun_o.
- Hold sig_in high after a rise → timeout_o exactly 65535 cycles after that rise; FSM returns to IDLE. The next two rises produce one valid result.
- Assert rst_n low 3 cycles after a rise that started the divider → outputs 0 immediately, no valid_o. After release, results resume on the second rise.
- Change the period from 20 to 50 cycles mid-stream → the first result after the change shows period_o=50. No stale mixing of H from the old period.
